bcd_time_counter: RTL

//  Parametrised BCD time-of-day counter (HH:MM:SS), the successor to the fixed free-running clock counter.

---
 rtl/bcd_time_counter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS time-of-day counter with seconds prescaler, run enable, 12/24-hour mode and validated load.
// Optional alarm comparator is included when the ALARM_EN macro is defined.
module bcd_time_counter #(
    parameter int unsigned CLK_PER_SEC = 50_000_000,
    parameter bit          HR24        = 1'b1,
    parameter int unsigned PRE_W       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] ld_hr_tens,
    input  logic [3:0] ld_hr_ones,
    input  logic [3:0] ld_min_tens,
    input  logic [3:0] ld_min_ones,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       ld_pm,
`ifdef ALARM_EN
    input  logic [3:0] al_hr_tens,
    input  logic [3:0] al_hr_ones,
    input  logic [3:0] al_min_tens,
    input  logic [3:0] al_min_ones,
    input  logic       al_pm,
    input  logic       al_arm,
    output logic       alarm_hit,
`endif
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_tick,
    output logic       load_err
);

    localparam logic [PRE_W-1:0] PRE_MAX     = PRE_W'(CLK_PER_SEC - 1);
    localparam logic [3:0]       RST_HR_TENS = HR24 ? 4'd0 : 4'd1;
    localparam logic [3:0]       RST_HR_ONES = HR24 ? 4'd0 : 4'd2;

    logic [PRE_W-1:0] pre;
    logic             tick_int;
    logic             ld_valid;

    logic [3:0] n_hr_tens, n_hr_ones, n_min_tens, n_min_ones, n_sec_tens, n_sec_ones;
    logic       n_pm;
    logic       n_min_wrap;
    logic       n_day_wrap;

    assign tick_int = en && (pre == PRE_MAX);

    // Load digit validation; hour range depends on the clock mode
    always_comb begin
        ld_valid = (ld_sec_tens <= 4'd5) && (ld_sec_ones <= 4'd9) &&
                   (ld_min_tens <= 4'd5) && (ld_min_ones <= 4'd9);
        if (HR24) begin
            ld_valid = ld_valid &&
                       (((ld_hr_tens <= 4'd1) && (ld_hr_ones <= 4'd9)) ||
                        ((ld_hr_tens == 4'd2) && (ld_hr_ones <= 4'd3)));
        end else begin
            ld_valid = ld_valid &&
                       (((ld_hr_tens == 4'd0) && (ld_hr_ones >= 4'd1) && (ld_hr_ones <= 4'd9)) ||
                        ((ld_hr_tens == 4'd1) && (ld_hr_ones <= 4'd2)));
        end
    end

    // Time one second ahead of the current registers
    always_comb begin
        n_hr_tens  = hr_tens;
        n_hr_ones  = hr_ones;
        n_min_tens = min_tens;
        n_min_ones = min_ones;
        n_sec_tens = sec_tens;
        n_sec_ones = sec_ones;
        n_pm       = pm;
        n_min_wrap = 1'b0;
        n_day_wrap = 1'b0;

        if (sec_ones != 4'd9) begin
            n_sec_ones = sec_ones + 4'd1;
        end else begin
            n_sec_ones = 4'd0;
            if (sec_tens != 4'd5) begin
                n_sec_tens = sec_tens + 4'd1;
            end else begin
                n_sec_tens = 4'd0;
                n_min_wrap = 1'b1;
                if (min_ones != 4'd9) begin
                    n_min_ones = min_ones + 4'd1;
                end else begin
                    n_min_ones = 4'd0;
                    if (min_tens != 4'd5) begin
                        n_min_tens = min_tens + 4'd1;
                    end else begin
                        n_min_tens = 4'd0;
                        if (HR24) begin
                            if ((hr_tens == 4'd2) && (hr_ones == 4'd3)) begin
                                n_hr_tens  = 4'd0;
                                n_hr_ones  = 4'd0;
                                n_day_wrap = 1'b1;
                            end else if (hr_ones == 4'd9) begin
                                n_hr_tens = hr_tens + 4'd1;
                                n_hr_ones = 4'd0;
                            end else begin
                                n_hr_ones = hr_ones + 4'd1;
                            end
                        end else begin
                            // 12 rolls to 01; 11 rolls to 12 and flips AM/PM
                            if ((hr_tens == 4'd1) && (hr_ones == 4'd2)) begin
                                n_hr_tens = 4'd0;
                                n_hr_ones = 4'd1;
                            end else if ((hr_tens == 4'd1) && (hr_ones == 4'd1)) begin
                                n_hr_ones  = 4'd2;
                                n_pm       = ~pm;
                                n_day_wrap = pm;
                            end else if (hr_ones == 4'd9) begin
                                n_hr_tens = hr_tens + 4'd1;
                                n_hr_ones = 4'd0;
                            end else begin
                                n_hr_ones = hr_ones + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef ALARM_EN
    logic al_match;

    assign al_match = al_arm &&
                      (n_hr_tens == al_hr_tens) && (n_hr_ones == al_hr_ones) &&
                      (n_min_tens == al_min_tens) && (n_min_ones == al_min_ones) &&
                      (HR24 || (n_pm == al_pm));
`endif

    // State update: reset beats load, load beats the second advance
    always_ff @(posedge clk) begin
        if (reset) begin
            pre      <= '0;
            hr_tens  <= RST_HR_TENS;
            hr_ones  <= RST_HR_ONES;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            pm       <= 1'b0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
`ifdef ALARM_EN
            alarm_hit <= 1'b0;
`endif
        end else begin
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
`ifdef ALARM_EN
            alarm_hit <= 1'b0;
`endif
            if (load) begin
                if (ld_valid) begin
                    pre      <= '0;
                    hr_tens  <= ld_hr_tens;
                    hr_ones  <= ld_hr_ones;
                    min_tens <= ld_min_tens;
                    min_ones <= ld_min_ones;
                    sec_tens <= ld_sec_tens;
                    sec_ones <= ld_sec_ones;
                    pm       <= HR24 ? 1'b0 : ld_pm;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (tick_int) begin
                    pre      <= '0;
                    hr_tens  <= n_hr_tens;
                    hr_ones  <= n_hr_ones;
                    min_tens <= n_min_tens;
                    min_ones <= n_min_ones;
                    sec_tens <= n_sec_tens;
                    sec_ones <= n_sec_ones;
                    pm       <= n_pm;
                    sec_tick <= 1'b1;
                    min_tick <= n_min_wrap;
                    day_tick <= n_day_wrap;
`ifdef ALARM_EN
                    alarm_hit <= n_min_wrap && al_match;
`endif
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

endmodule
